// File: rtl/uart_ram_programmer_pkg.sv
// Shared constants and helpers for the UART RAM programmer.
package uart_ram_programmer_pkg;

    // Payload words are assembled from this many bytes, least-significant first.
    localparam int unsigned BYTES_PER_WORD = 4;

    // Clock cycles per UART bit. Integer division, so the real baud rate is
    // slightly faster than nominal when CLK_FREQ is not an exact multiple.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_ram_programmer_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, start-glitch
// rejection and stop-bit framing check. Emits a one-cycle valid per good byte.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]    sync_q;
    logic          prev_q;
    logic          rx_s;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;

    assign rx_s    = sync_q[1];
    assign byte_o  = byte_q;
    assign valid_o = valid_q;

    // Synchronize the asynchronous line; idle-high reset avoids a false start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            prev_q <= sync_q[1];
        end
    end

    // Frame state machine: start check at half bit, then one sample per bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Frame state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/uart_ram_programmer.sv
// UART RAM loader: detects a magic byte sequence, then receives a word count
// and that many little-endian words, emitting one write strobe per word while
// holding the system in reset. A silent line ends programming early.
module uart_ram_programmer
    import uart_ram_programmer_pkg::*;
#(
    parameter int unsigned                CLK_FREQ     = 50_000_000,
    parameter int unsigned                BAUD_RATE    = 115200,
    parameter int unsigned                SEQ_LENGTH   = 9,
    parameter logic [SEQ_LENGTH*8-1:0]    MAGIC_SEQ    = "CERESTEST",
    parameter int unsigned                BREAK_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        uart_rx_i,
    output logic [31:0] prog_addr_o,
    output logic [31:0] prog_data_o,
    output logic        prog_valid_o,
    output logic        prog_mode_o,
    output logic        system_reset_o
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned IDXW = $clog2(SEQ_LENGTH + 1);
    localparam int unsigned TW   = $clog2(BREAK_CYCLES + 1);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(SEQ_LENGTH - 1);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(BREAK_CYCLES - 1);
    localparam logic [1:0]      LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Byte i of the magic string, byte 0 being the first one on the wire.
    function automatic logic [7:0] magic_byte(input int unsigned i);
        logic [SEQ_LENGTH*8-1:0] s;
        s = MAGIC_SEQ >> ((SEQ_LENGTH - 1 - i) * 8);
        return s[7:0];
    endfunction

    logic [7:0]      rx_byte;
    logic            rx_valid;

    logic [1:0]      state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [31:0]     word_count_q, word_count_d;
    logic [31:0]     words_q, words_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic            valid_q, valid_d;
    logic            mode_q, mode_d;
    logic            sysrst_q, sysrst_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [31:0]     count_full;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .rx_i   (uart_rx_i),
        .byte_o (rx_byte),
        .valid_o(rx_valid)
    );

    assign prog_addr_o    = addr_q;
    assign prog_data_o    = data_q;
    assign prog_valid_o   = valid_q;
    assign prog_mode_o    = mode_q;
    assign system_reset_o = sysrst_q;
    assign count_full     = {rx_byte, word_count_q[31:8]};

    // Magic matcher, load FSM and inter-byte timeout.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        byte_cnt_d   = byte_cnt_q;
        word_count_d = word_count_q;
        words_d      = words_q;
        addr_d       = valid_q ? addr_q + 32'd1 : addr_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        mode_d       = mode_q;
        sysrst_d     = sysrst_q;
        timer_d      = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_byte == magic_byte(32'(idx_q))) begin
                        if (idx_q == IDX_LAST) begin
                            state_d    = ST_COUNT;
                            idx_d      = '0;
                            mode_d     = 1'b1;
                            sysrst_d   = 1'b1;
                            byte_cnt_d = '0;
                            words_d    = '0;
                            timer_d    = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        // A mismatching byte may itself start a new sequence.
                        idx_d = (rx_byte == magic_byte(0)) ? IDXW'(1) : '0;
                    end
                end
            end
            ST_COUNT: begin
                if (rx_valid) begin
                    timer_d      = '0;
                    word_count_d = count_full;
                    byte_cnt_d   = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        if (count_full == 32'd0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_DATA;
                            addr_d  = '0;
                        end
                    end
                end else if (timer_q == TMO_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    timer_d    = '0;
                    data_d     = {rx_byte, data_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        valid_d = 1'b1;
                        words_d = words_q + 32'd1;
                        if (words_q + 32'd1 == word_count_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end else if (timer_q == TMO_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                idx_d    = '0;
                mode_d   = 1'b0;
                sysrst_d = 1'b0;
            end
        endcase
    end

    // Loader state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            byte_cnt_q   <= '0;
            word_count_q <= '0;
            words_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            mode_q       <= 1'b0;
            sysrst_q     <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            byte_cnt_q   <= byte_cnt_d;
            word_count_q <= word_count_d;
            words_q      <= words_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            mode_q       <= mode_d;
            sysrst_q     <= sysrst_d;
            timer_q      <= timer_d;
        end
    end

endmodule

// File: tb/tb_uart_ram_programmer.sv
// Directed bench for uart_ram_programmer: 10 clocks per bit, 500-cycle break.
module tb_uart_ram_programmer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        prog_valid;
    logic        prog_mode;
    logic        system_reset;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_ram_programmer #(
        .CLK_FREQ    (1_000_000),
        .BAUD_RATE   (100_000),
        .SEQ_LENGTH  (9),
        .MAGIC_SEQ   ("CERESTEST"),
        .BREAK_CYCLES(500)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .uart_rx_i     (rx),
        .prog_addr_o   (prog_addr),
        .prog_data_o   (prog_data),
        .prog_valid_o  (prog_valid),
        .prog_mode_o   (prog_mode),
        .system_reset_o(system_reset)
    );

    // Write log and output-property monitor, sampled on the falling edge.
    logic [31:0] wr_addr [0:15];
    logic [31:0] wr_data [0:15];
    logic        wr_mode [0:15];
    int          wr_cnt      = 0;
    int          mode_cycles = 0;
    int          sr_mismatch = 0;
    int          long_pulse  = 0;
    logic        prev_valid  = 1'b0;

    always @(negedge clk) begin
        if (prog_valid) begin
            if (wr_cnt < 16) begin
                wr_addr[wr_cnt] = prog_addr;
                wr_data[wr_cnt] = prog_data;
                wr_mode[wr_cnt] = prog_mode;
            end
            wr_cnt++;
        end
        if (prog_valid && prev_valid) long_pulse++;
        prev_valid = prog_valid;
        if (prog_mode) mode_cycles++;
        if (prog_mode !== system_reset) sr_mismatch++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame followed by one idle bit time.
    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        rx = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(10);
        end
        rx = good_stop;
        tick(10);
        rx = 1'b1;
        tick(10);
    endtask

    // Sends the first n bytes of s, most-significant byte first.
    task automatic send_seq(input logic [191:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(s[(n - 1 - i) * 8 +: 8], 1'b1);
        end
    endtask

    task automatic wait_mode_low(input string name);
        int n;
        n = 0;
        while (prog_mode && n < 1000) begin
            tick(1);
            n++;
        end
        if (prog_mode) begin
            checks++;
            errors++;
            $display("FAIL %s mode still high after 1000 cycles, required low", name);
        end
        tick(20);
    endtask

    typedef struct {
        logic [191:0] s;
        int           n;
        logic         exp_mode;
        int           exp_wr;
        logic [31:0]  d0;
        logic [31:0]  d1;
    } vec_t;

    vec_t vec [0:5];

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base_wr;
        int base_mode;
        int n;

        vec[0] = '{192'({"CERESTEST", 32'h02000000, 32'hEFBEADDE, 32'h78563412}), 21, 1'b1, 2,
                   32'hDEADBEEF, 32'h12345678};
        vec[1] = '{192'({"CERXCERESTEST", 32'h00000000}), 17, 1'b1, 0, 32'h0, 32'h0};
        vec[2] = '{192'({"CCERESTEST", 32'h01000000, 32'h01020304}), 18, 1'b1, 1,
                   32'h04030201, 32'h0};
        vec[3] = '{192'({"CERESTEX", "CERESTEST", 32'h00000000}), 21, 1'b1, 0, 32'h0, 32'h0};
        vec[4] = '{192'({"CERESTESC", "ERESTEST", 32'h00000000}), 21, 1'b1, 0, 32'h0, 32'h0};
        vec[5] = '{192'({"CEREZTEST"}), 9, 1'b0, 0, 32'h0, 32'h0};

        rx    = 1'b1;
        rst_n = 1'b0;
        tick(5);
        check("reset_addr", prog_addr, 32'h0);
        check("reset_data", prog_data, 32'h0);
        check("reset_valid", {31'b0, prog_valid}, 32'h0);
        check("reset_mode", {31'b0, prog_mode}, 32'h0);
        check("reset_sysrst", {31'b0, system_reset}, 32'h0);
        rst_n = 1'b1;
        tick(20);

        // Table of complete transactions.
        for (int v = 0; v < 6; v++) begin
            base_wr   = wr_cnt;
            base_mode = mode_cycles;
            send_seq(vec[v].s, vec[v].n);
            wait_mode_low($sformatf("vec%0d_exit", v));
            check($sformatf("vec%0d_mode_seen", v), {31'b0, mode_cycles != base_mode},
                  {31'b0, vec[v].exp_mode});
            check($sformatf("vec%0d_writes", v), wr_cnt - base_wr, vec[v].exp_wr);
            if (vec[v].exp_wr >= 1) begin
                check($sformatf("vec%0d_addr0", v), wr_addr[base_wr], 32'd0);
                check($sformatf("vec%0d_data0", v), wr_data[base_wr], vec[v].d0);
                check($sformatf("vec%0d_mode_at_wr0", v), {31'b0, wr_mode[base_wr]}, 32'd1);
            end
            if (vec[v].exp_wr >= 2) begin
                check($sformatf("vec%0d_addr1", v), wr_addr[base_wr + 1], 32'd1);
                check($sformatf("vec%0d_data1", v), wr_data[base_wr + 1], vec[v].d1);
                check($sformatf("vec%0d_mode_at_wr1", v), {31'b0, wr_mode[base_wr + 1]}, 32'd1);
            end
        end

        // Mode window: rises on the last magic byte, falls right after the last write.
        send_seq(192'("CERESTES"), 8);
        check("t1_mode_before_last_magic", {31'b0, prog_mode}, 32'd0);
        send_byte("T", 1'b1);
        check("t1_mode_after_magic", {31'b0, prog_mode}, 32'd1);
        check("t1_sysrst_after_magic", {31'b0, system_reset}, 32'd1);
        base_wr = wr_cnt;
        send_seq(192'({32'h02000000, 32'hEFBEADDE, 32'h78563412}), 12);
        check("t1_mode_after_last_word", {31'b0, prog_mode}, 32'd0);
        check("t1_sysrst_after_last_word", {31'b0, system_reset}, 32'd0);
        check("t1_writes", wr_cnt - base_wr, 32'd2);
        tick(20);

        // Timeout: count 3, one word, half a word, then silence.
        base_wr = wr_cnt;
        send_seq(192'({"CERESTEST", 32'h03000000, 32'h11223344, 16'hAABB}), 19);
        n = 0;
        while (prog_mode && n < 1000) begin
            tick(1);
            n++;
        end
        checks++;
        if (n < 480 || n > 500) begin
            errors++;
            $display("FAIL t4_timeout_delay actual=%0d cycles required=480..500", n);
        end
        tick(20);
        check("t4_writes", wr_cnt - base_wr, 32'd1);
        check("t4_addr0", wr_addr[base_wr], 32'd0);
        check("t4_data0", wr_data[base_wr], 32'h44332211);

        // Framing error inside the magic sequence drops that byte.
        base_mode = mode_cycles;
        send_seq(192'("CERE"), 4);
        send_byte("S", 1'b0);
        send_seq(192'("TEST"), 4);
        tick(20);
        check("t5_no_mode_after_bad_stop", {31'b0, mode_cycles != base_mode}, 32'd0);
        send_seq(192'({"CERESTEST", 32'h00000000}), 13);
        wait_mode_low("t5_exit");
        check("t5_mode_after_resend", {31'b0, mode_cycles != base_mode}, 32'd1);

        // Asynchronous reset mid-frame during DATA.
        base_wr = wr_cnt;
        send_seq(192'({"CERESTEST", 32'h02000000, 32'h11223344, 16'h5566}), 19);
        rx = 1'b0;
        tick(30);
        check("t6_mode_before_reset", {31'b0, prog_mode}, 32'd1);
        check("t6_writes_before_reset", wr_cnt - base_wr, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_reset_addr", prog_addr, 32'h0);
        check("t6_reset_data", prog_data, 32'h0);
        check("t6_reset_valid", {31'b0, prog_valid}, 32'h0);
        check("t6_reset_mode", {31'b0, prog_mode}, 32'h0);
        check("t6_reset_sysrst", {31'b0, system_reset}, 32'h0);
        rx = 1'b1;
        tick(5);
        rst_n = 1'b1;
        tick(20);
        base_wr = wr_cnt;
        send_seq(192'({"CERESTEST", 32'h01000000, 32'h0DF0FECA}), 17);
        wait_mode_low("t6_exit");
        check("t6_writes_after", wr_cnt - base_wr, 32'd1);
        check("t6_addr_after", wr_addr[base_wr], 32'd0);
        check("t6_data_after", wr_data[base_wr], 32'hCAFEF00D);

        check("valid_single_cycle", long_pulse, 32'd0);
        check("sysrst_tracks_mode", sr_mismatch, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_ram_programmer.md
Name: uart_ram_programmer

Overview:
- UART-driven loader that sits beside the system RAM wrapper.
- Watches a serial RX line for a fixed magic byte sequence. On a match it enters programming mode and holds the system in reset.
- It then receives a 32-bit word count followed by that many 32-bit data words. Each word is emitted as an address/data/valid write pulse toward the RAM.
- Programming mode ends, and system reset is released, when the last word is written or the line goes silent for too long.

Parameters:
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- BAUD_RATE, 115200: UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division, required to be >= 4.
- MAGIC_SEQ, "CERESTEST": packed byte string of SEQ_LENGTH*8 bits. The most-significant byte is received first.
- SEQ_LENGTH, 9: number of bytes in MAGIC_SEQ.
- BREAK_CYCLES, 1_000_000: inter-byte silence timeout in clock cycles, applied while in programming mode.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; one clock, asynchronous, active-low
- uart_rx_i  in  1  serial input; idles high
- prog_addr_o  out  32  word index, not a byte address
- prog_data_o  out  32  word to write
- prog_valid_o  out  1  one-cycle write strobe
- prog_mode_o  out  1  high while programming
- system_reset_o  out  1  high while the rest of the system must be held in reset

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the magic index is 0.
- RX input path:
  - uart_rx_i passes through a 2-flop synchronizer, reset value 1.
  - Frame format is 8N1, LSB first.
  - Start is detected on a falling edge. The start bit is re-checked at CLKS_PER_BIT/2; if the line is high there, the frame is aborted as a glitch.
  - Each data bit and the stop bit are sampled every CLKS_PER_BIT thereafter.
  - If the stop bit is 0 (framing error), the byte is discarded.
  - A good byte produces a one-cycle internal rx_valid with rx_byte.
- FSM states:
  - IDLE / MATCH:
    - On each rx_valid, compare rx_byte with magic byte [idx].
    - On equal: idx++. When idx reaches SEQ_LENGTH, go to COUNT, set prog_mode_o=1 and system_reset_o=1, and clear the byte and word counters.
    - On mismatch: idx becomes 1 if rx_byte equals magic byte 0, otherwise 0.
  - COUNT:
    - Collect 4 bytes, little-endian, into word_count.
    - If word_count==0, go to DONE. Otherwise go to DATA with prog_addr_o=0.
  - DATA:
    - Collect 4 bytes, little-endian, into prog_data_o.
    - On the 4th byte, pulse prog_valid_o for exactly one cycle, with prog_addr_o and prog_data_o stable during the pulse.
    - prog_addr_o increments in the cycle after the pulse.
    - When the number of words written equals word_count, go to DONE.
  - DONE (one cycle): prog_mode_o=0 and system_reset_o=0, then return to IDLE with idx=0.
- Timeout:
  - In COUNT or DATA, a counter resets on every rx_valid.
  - When it reaches BREAK_CYCLES, go to DONE. Partial bytes and partial words are discarded, and no prog_valid_o is issued for them.
- Magic bytes received while in COUNT or DATA are ordinary payload, not re-detection.
- prog_addr_o wraps modulo 2^32; the consumer truncates it to RAM depth.
- Asynchronous reset mid-frame or mid-programming returns to the reset state immediately.
- Outputs prog_mode_o and system_reset_o are registered and glitch-free.

Decomposition:
- No shared-package content is required; the FSM state enum stays local.
- One sub-module is natural: uart_rx_byte, parameterized by CLKS_PER_BIT. Ports: clk_i, rst_ni, rx_i, byte_o[7:0], valid_o. It contains the synchronizer, the bit timer and framing check.
- The top level contains the magic matcher, the load FSM and the timeout counter.

Test Plan:
Bench parameters: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (10 clocks/bit), MAGIC_SEQ="CERESTEST", BREAK_CYCLES=500.
1. Send "CERESTEST", count 02 00 00 00, words EF BE AD DE and 78 56 34 12 -> two prog_valid_o pulses: (addr 0, data 0xDEADBEEF) and (addr 1, data 0x12345678). prog_mode_o and system_reset_o are high from the last magic stop bit until the cycle after the 2nd write, then return to 0.
2. Send "CERXCERESTEST" then count 0 -> the mismatch restarts matching and detection still occurs. prog_mode_o goes high, then drops after the count with no prog_valid_o.
3. Send "CCERESTEST" -> the repeated first byte is handled and the mode is entered.
4. After magic, send count=3 and one full word, then 2 bytes, then silence -> one write (addr 0). prog_mode_o drops 500 cycles after the last byte with no further prog_valid_o.
5. Send a frame whose stop bit is 0 in the middle of the magic sequence -> the byte is dropped and the mode is not entered unless the sequence is re-sent correctly.
6. Assert rst_ni low during DATA -> all outputs are 0 immediately. A subsequent full sequence works normally, starting again at addr 0.
